// File: rtl/peres_gate.sv
// Peres reversible gate (forward or inverse) over WIDTH independent bit-lanes,
// with a single registered output stage and a valid/ready handshake on both sides.
module peres_gate #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inv,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] o1,
  output logic [WIDTH-1:0] o2,
  output logic [WIDTH-1:0] o3
);

  logic             xfer_in;
  logic [WIDTH-1:0] p_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic [WIDTH-1:0] r_nxt;

  // The stage can take a new result when empty or when its current result drains now.
  assign in_ready = ~out_valid | out_ready;
  assign xfer_in  = in_valid & in_ready;

  // Inverse uses Q in place of B so that inverse(forward(x)) recovers C.
  always_comb begin
    p_nxt = a;
    q_nxt = a ^ b;
    r_nxt = (a & b) ^ c;
    if (inv) begin
      r_nxt = (a & q_nxt) ^ c;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      o1        <= '0;
      o2        <= '0;
      o3        <= '0;
    end else if (xfer_in) begin
      out_valid <= 1'b1;
      o1        <= p_nxt;
      o2        <= q_nxt;
      o3        <= r_nxt;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_peres_gate.sv
// Directed bench for peres_gate: a 1-bit and an 8-bit instance share clock,
// reset and handshake controls; each check compares against hand-computed values.
`timescale 1ns/100ps
module tb_peres_gate;

  logic       clk;
  logic       rst;
  logic       inv;
  logic       in_valid;
  logic       out_ready;
  logic       in_ready_1, in_ready_8;
  logic       out_valid_1, out_valid_8;
  logic [0:0] a1, b1, c1, o1_1, o2_1, o3_1;
  logic [7:0] a8, b8, c8, o1_8, o2_8, o3_8;

  int n_chk;
  int n_bad;

  logic [2:0] fwd_tab [8];
  logic [2:0] inv_tab [8];

  peres_gate #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst(rst), .inv(inv), .in_valid(in_valid), .in_ready(in_ready_1),
    .a(a1), .b(b1), .c(c1), .out_valid(out_valid_1), .out_ready(out_ready),
    .o1(o1_1), .o2(o2_1), .o3(o3_1)
  );

  peres_gate #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst(rst), .inv(inv), .in_valid(in_valid), .in_ready(in_ready_8),
    .a(a8), .b(b8), .c(c8), .out_valid(out_valid_8), .out_ready(out_ready),
    .o1(o1_8), .o2(o2_8), .o3(o3_8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] o_w1();
    return {o1_1, o2_1, o3_1};
  endfunction

  task automatic drive_w1(input logic [2:0] abc);
    a1 = abc[2];
    b1 = abc[1];
    c1 = abc[0];
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $display("test done: total=%0d bad=%0d", n_chk + 1, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0;
    n_bad = 0;
    fwd_tab = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b110, 3'b111, 3'b101, 3'b100};
    inv_tab = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b111, 3'b110, 3'b100, 3'b101};

    rst = 1'b1; inv = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a1 = '0; b1 = '0; c1 = '0; a8 = '0; b8 = '0; c8 = '0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid_1), 64'd0);
    chk("rst_o_w1", 64'(o_w1()), 64'd0);
    chk("rst_o_w8", 64'({o1_8, o2_8, o3_8}), 64'd0);
    chk("rst_in_ready", 64'(in_ready_1), 64'd1);

    // Forward sweep; first vector offered in the same cycle reset releases.
    rst = 1'b0; out_ready = 1'b1; in_valid = 1'b1; inv = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) begin
        @(negedge clk);
        chk($sformatf("fwd_%0d", k - 1), 64'(o_w1()), 64'(fwd_tab[k - 1]));
        chk($sformatf("fwd_valid_%0d", k - 1), 64'(out_valid_1), 64'd1);
      end
      drive_w1(3'(k));
    end
    @(negedge clk);
    chk("fwd_7", 64'(o_w1()), 64'(fwd_tab[7]));
    in_valid = 1'b0;
    @(negedge clk);
    chk("drain_valid", 64'(out_valid_1), 64'd0);

    // Inverse sweep.
    inv = 1'b1; in_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) begin
        @(negedge clk);
        chk($sformatf("inv_%0d", k - 1), 64'(o_w1()), 64'(inv_tab[k - 1]));
      end
      drive_w1(3'(k));
    end
    @(negedge clk);
    chk("inv_7", 64'(o_w1()), 64'(inv_tab[7]));

    // Round trip: inverse applied to forward outputs returns the original abc.
    for (int k = 0; k < 8; k++) begin
      if (k > 0) begin
        @(negedge clk);
        chk($sformatf("round_%0d", k - 1), 64'(o_w1()), 64'(k - 1));
      end
      drive_w1(fwd_tab[k]);
    end
    @(negedge clk);
    chk("round_7", 64'(o_w1()), 64'd7);

    // 8-bit lanes, forward then inverse.
    inv = 1'b0; a8 = 8'hF0; b8 = 8'hCC; c8 = 8'hAA;
    @(negedge clk);
    chk("w8_fwd_o1", 64'(o1_8), 64'h00F0);
    chk("w8_fwd_o2", 64'(o2_8), 64'h003C);
    chk("w8_fwd_o3", 64'(o3_8), 64'h006A);
    inv = 1'b1;
    @(negedge clk);
    chk("w8_inv_o3", 64'(o3_8), 64'h009A);
    chk("w8_valid", 64'(out_valid_8), 64'd1);

    // Backpressure: 110 -> 101 held while 111 waits.
    inv = 1'b0; drive_w1(3'b110);
    @(negedge clk);
    chk("bp_first", 64'(o_w1()), 64'b101);
    out_ready = 1'b0; drive_w1(3'b111);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("bp_in_ready_%0d", k), 64'(in_ready_1), 64'd0);
      @(negedge clk);
      chk($sformatf("bp_hold_%0d", k), 64'(o_w1()), 64'b101);
      chk($sformatf("bp_valid_%0d", k), 64'(out_valid_1), 64'd1);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_in_ready_rel", 64'(in_ready_1), 64'd1);
    @(negedge clk);
    chk("bp_second", 64'(o_w1()), 64'b100);
    chk("bp_valid_second", 64'(out_valid_1), 64'd1);

    // Mid-operation reset with a result pending.
    in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(out_valid_1), 64'd0);
    chk("mid_rst_o_w1", 64'(o_w1()), 64'd0);
    chk("mid_rst_o_w8", 64'({o1_8, o2_8, o3_8}), 64'd0);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b1; out_ready = 1'b1; drive_w1(3'b101);
    @(negedge clk);
    chk("post_rst_o", 64'(o_w1()), 64'b111);
    chk("post_rst_valid", 64'(out_valid_1), 64'd1);
    in_valid = 1'b0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/peres_gate.md
PERES_GATE -- requirements
Module: peres_gate

Interface
REQ-001 Parameter WIDTH, default 1: number of independent bit-lanes; legal range 1..64.
REQ-002 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port rst  input  1  reset, asynchronous and active-high.
REQ-004 Port inv  input  1  mode select: 0 = forward Peres, 1 = inverse Peres; sampled together with a/b/c.
REQ-005 Port in_valid  input  1  a, b, c and inv are valid this cycle.
REQ-006 Port in_ready  output  1  the block accepts input this cycle.
REQ-007 Port a  input  WIDTH  operand A, one bit per lane.
REQ-008 Port b  input  WIDTH  operand B.
REQ-009 Port c  input  WIDTH  operand C.
REQ-010 Port out_valid  output  1  o1, o2 and o3 hold a result.
REQ-011 Port out_ready  input  1  downstream accepts the result this cycle.
REQ-012 Port o1  output  WIDTH  result P.
REQ-013 Port o2  output  WIDTH  result Q.
REQ-014 Port o3  output  WIDTH  result R.

Function
REQ-015 The forward mapping (inv=0), per lane i, SHALL be: o1=a, o2=a XOR b, o3=(a AND b) XOR c.
REQ-016 The inverse mapping (inv=1), per lane i, SHALL be: o1=a, o2=a XOR b, o3=(a AND (a XOR b)) XOR c, so that inverse(forward(x))=x for every x.
REQ-017 Lanes SHALL be fully independent, with no carry or interaction between bit positions.
REQ-018 A transfer in SHALL occur on a rising edge where in_valid=1 and in_ready=1.
REQ-019 The result of a transfer SHALL appear on o1/o2/o3 with out_valid=1 one cycle later (latency 1).
REQ-020 in_ready SHALL equal (NOT out_valid) OR out_ready, evaluated combinationally.
REQ-021 Throughput SHALL be 1 transfer/cycle while out_ready=1.
REQ-022 While out_valid=1 and out_ready=0, o1/o2/o3 and out_valid SHALL hold stable.
REQ-023 On a simultaneous output transfer and input transfer, the output register SHALL load the new result and keep out_valid=1.
REQ-024 On an output transfer with no input transfer, out_valid SHALL fall to 0 on that edge, and o1/o2/o3 MAY hold their last value.
REQ-025 a/b/c/inv SHALL be ignored when no input transfer occurs.
REQ-026 No combinational path SHALL exist from a/b/c/inv to o1/o2/o3; outputs are registered.

Reset
REQ-027 While rst=1, out_valid, o1, o2 and o3 SHALL be 0 immediately, without waiting for a clock edge.
REQ-028 A reset asserted mid-operation SHALL discard the pending result.
REQ-029 The first transfer SHALL be accepted on the first rising edge after rst deasserts.

Verification
REQ-030 WIDTH=1, inv=0, out_ready=1: sweep abc=000..111, one per cycle -> o1o2o3 = 000, 001, 010, 011, 110, 111, 101, 100, each one cycle after its input.
REQ-031 inv=1, same sweep -> o1o2o3 = 000, 001, 010, 011, 111, 110, 100, 101, and feeding the forward outputs back with inv=1 returns the original abc.
REQ-032 Backpressure: send abc=110, hold out_ready=0 for 3 cycles while offering abc=111 -> o=101 stays stable, in_ready=0, and abc=111 is accepted only after out_ready=1, giving o=100.
REQ-033 Assert rst for half a cycle while out_valid=1 -> out_valid=0 and o1=o2=o3=0 before the next edge; the next input is accepted on the first edge after release.
REQ-034 WIDTH=8, a=8'hF0, b=8'hCC, c=8'hAA, inv=0 -> o1=8'hF0, o2=8'h3C, o3=8'h6A.
